bit_serial_adder: RTL
=====================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; legal range is 1 to 64.
REQ-003 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-004 Port rst_n, input, 1, SHALL be the synchronous active-low reset.
REQ-005 Port in_valid, input, 1, SHALL indicate that a, b, ci and sub are valid.
REQ-006 Port in_ready, output, 1, SHALL be high when the block accepts operands.
REQ-007 Ports a and b, input, WIDTH each, SHALL be the unsigned/two's-complement operands.
REQ-008 Port ci, input, 1, SHALL be the carry-in; it is ignored when sub=1.
REQ-009 Port sub, input, 1, SHALL select the operation: 0 computes a+b+ci, 1 computes a-b.
REQ-010 Port sum, output, WIDTH, SHALL be the result.
REQ-011 Port co, output, 1, SHALL be the carry-out; for subtraction it is the not-borrow.
REQ-012 Port ovf, output, 1, SHALL be the signed overflow flag (carry into MSB XOR carry out of MSB).
REQ-013 Port out_valid, output, 1, SHALL indicate that sum, co and ovf are valid.
REQ-014 Port out_ready, input, 1, SHALL be the downstream acceptance signal.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready=0.
REQ-017 An operation is accepted on an edge where in_valid and in_ready are both 1. On that edge:
- load A from a
- load B from b, or from ~b when sub=1
- load carry register C from ci, or 1 when sub=1
- clear the sum shift register
- load the bit counter with WIDTH
- go to RUN
REQ-018 In RUN, each edge SHALL:
- compute s = A[0]^B[0]^C and c = majority(A[0],B[0],C)
- shift s into the MSB of the sum register
- shift A and B right by one
- set C to c
- decrement the counter
REQ-019 On the RUN edge where the counter reaches 0, the block SHALL:
- capture the carry into bit WIDTH-1 for the ovf computation
- go to DONE
REQ-020 out_valid SHALL rise exactly WIDTH clock edges after the accept edge.
REQ-021 In DONE, the outputs SHALL behave as follows:
- out_valid=1
- sum, co and ovf stable
- in_valid ignored
REQ-022 An edge in DONE with out_ready=1 SHALL return the FSM to IDLE, so in_ready=1 on the following cycle; no same-cycle re-accept.
REQ-023 out_valid SHALL be 0 in IDLE and RUN.
REQ-024 sum, co and ovf SHALL retain the last result in IDLE until the next accept.
REQ-025 For WIDTH=1, RUN SHALL last a single edge and ovf SHALL equal C_in XOR co.
REQ-026 The counter width SHALL be $clog2(WIDTH+1).
REQ-027 The result SHALL equal the WIDTH-bit modular sum with the correct carry for all operand values, including all-ones and all-zeros.

Reset
REQ-028 While rst_n=0 at an edge, the block SHALL enter IDLE and clear A, B, C, the counter, sum, co, ovf and out_valid; in_ready SHALL be 1 on the cycle after reset.
REQ-029 A reset asserted during RUN or DONE SHALL abort the operation with no output pulse.

Structure
REQ-030 Package bsa_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the WIDTH range check constants.
REQ-031 The one-bit combinational adder SHALL be a sub-module named fa_cell (inputs x, y, cin; outputs s, cout), instantiated once.

Verification
REQ-032 Add with carry: WIDTH=8, a=8'hFF, b=8'h01, ci=0, sub=0 -> sum=8'h00, co=1, ovf=0, out_valid rising exactly 8 edges after accept.
REQ-033 Signed overflow on add: a=8'h7F, b=8'h01, ci=0 -> sum=8'h80, co=0, ovf=1.
REQ-034 Subtract: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, co=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, co=1, ovf=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE, then next operation accepted.
REQ-036 Reset mid-run: assert rst_n=0 at the 4th RUN edge -> next cycle sum=0, co=0, ovf=0, out_valid=0, in_ready=1.
REQ-037 Minimum width: WIDTH=1, a=1, b=1, ci=1 -> sum=1, co=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared state encoding and width limits for the bit-serial adder
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit full adder used as the serial datapath
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first serial add/subtract with valid/ready handshakes
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("bit_serial_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             co_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Each new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_s;
  end else begin : g_sum_wn
    assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sr          <= '0;
      b_sr          <= '0;
      sum_sr        <= '0;
      c_reg         <= 1'b0;
      cnt           <= '0;
      co_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_sr         <= a;
            b_sr         <= sub ? ~b : b;
            c_reg        <= sub ? 1'b1 : ci;
            sum_sr       <= '0;
            cnt          <= CNT_LOAD;
            in_ready_reg <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c_reg  <= fa_c;
          cnt    <= cnt - 1'b1;
          // On the MSB step c_reg still holds the carry into the MSB.
          if (cnt == CNT_LAST) begin
            co_reg        <= fa_c;
            ovf_reg       <= c_reg ^ fa_c;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_sr;
  assign co        = co_reg;
  assign ovf       = ovf_reg;

endmodule
